role_ctrl_regs: RTL and testbench

//  AXI4-Lite responder that exposes the role's control/status registers to the host-side initiator in the shell.

---
 rtl/role_ctrl_pkg.sv | 30 +++
 rtl/role_ctrl_regs.sv | 218 +++++++++++++++++++++
 tb/tb_role_ctrl_regs.sv | 379 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/role_ctrl_pkg.sv
// Shared definitions for the role control/status register block:
// register offsets (word index), AXI response codes, FSM state types.
package role_ctrl_pkg;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_SRC    = 3'd2;
    localparam logic [2:0] REG_DST    = 3'd3;
    localparam logic [2:0] REG_LEN    = 3'd4;
    localparam logic [2:0] REG_CYCLES = 3'd5;
    localparam logic [2:0] REG_ID     = 3'd6;
    localparam logic [2:0] REG_RSVD   = 3'd7;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_t;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

    // Merge a new write word into an existing register under byte enables.
    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[i*8 +: 8] = strb[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/role_ctrl_regs.sv
// AXI4-Lite responder exposing the role's control/status registers:
// start pulse, soft reset, job descriptor, busy/done status and cycle count.
module role_ctrl_regs
    import role_ctrl_pkg::*;
#(
    parameter int          ADDR_W  = 8,
    parameter int          DATA_W  = 32,
    parameter logic [31:0] CORE_ID = 32'h5A5A0001
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   s_awaddr,
    input  logic                s_awvalid,
    output logic                s_awready,
    input  logic [DATA_W-1:0]   s_wdata,
    input  logic [DATA_W/8-1:0] s_wstrb,
    input  logic                s_wvalid,
    output logic                s_wready,
    output logic [1:0]          s_bresp,
    output logic                s_bvalid,
    input  logic                s_bready,
    input  logic [ADDR_W-1:0]   s_araddr,
    input  logic                s_arvalid,
    output logic                s_arready,
    output logic [DATA_W-1:0]   s_rdata,
    output logic [1:0]          s_rresp,
    output logic                s_rvalid,
    input  logic                s_rready,
    output logic                role_start,
    output logic                role_srst,
    output logic [31:0]         role_src_addr,
    output logic [31:0]         role_dst_addr,
    output logic [31:0]         role_len,
    input  logic                role_busy,
    input  logic                role_done
);

    w_state_t    w_state_r, w_next_s;
    r_state_t    r_state_r, r_next_s;
    logic        ready_en_r;
    logic        awready_s, wready_s, bvalid_s, arready_s, rvalid_s;
    logic        wr_fire_s, rd_fire_s, ctrl_wr_s, start_accept_s, done_w1c_s;
    logic [2:0]  wr_sel_s, rd_sel_s;
    logic [31:0] rd_mux_s, rdata_r;
    logic        srst_r, done_r, role_start_r;
    logic [31:0] src_r, dst_r, len_r, cycles_r;
    logic        unused_addr_s;

    assign unused_addr_s = ^{s_awaddr[ADDR_W-1:5], s_awaddr[1:0],
                             s_araddr[ADDR_W-1:5], s_araddr[1:0]};

    assign wr_sel_s       = s_awaddr[4:2];
    assign rd_sel_s       = s_araddr[4:2];
    assign wr_fire_s      = awready_s;
    assign rd_fire_s      = arready_s && s_arvalid;
    assign ctrl_wr_s      = wr_fire_s && (wr_sel_s == REG_CTRL) && s_wstrb[0];
    // A write that also raises srst must not start the role.
    assign start_accept_s = ctrl_wr_s && s_wdata[0] && !s_wdata[1] && !role_busy && !srst_r;
    assign done_w1c_s     = wr_fire_s && (wr_sel_s == REG_STATUS) && s_wstrb[0] && s_wdata[1];

    // Keeps all ready outputs low while reset is asserted and for the first cycle after.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_r <= 1'b0;
            w_state_r  <= W_IDLE;
            r_state_r  <= R_IDLE;
        end else begin
            ready_en_r <= 1'b1;
            w_state_r  <= w_next_s;
            r_state_r  <= r_next_s;
        end
    end

    // Write channel FSM: AW and W accepted together only.
    always_comb begin
        w_next_s  = w_state_r;
        awready_s = 1'b0;
        wready_s  = 1'b0;
        bvalid_s  = 1'b0;
        case (w_state_r)
            W_IDLE: begin
                if (ready_en_r && s_awvalid && s_wvalid) begin
                    awready_s = 1'b1;
                    wready_s  = 1'b1;
                    w_next_s  = W_RESP;
                end else begin
                    w_next_s  = W_IDLE;
                end
            end
            W_RESP: begin
                bvalid_s = 1'b1;
                if (s_bready) begin
                    w_next_s = W_IDLE;
                end else begin
                    w_next_s = W_RESP;
                end
            end
            default: w_next_s = W_IDLE;
        endcase
    end

    // Read channel FSM: one-cycle latency, data held until accepted.
    always_comb begin
        r_next_s  = r_state_r;
        arready_s = 1'b0;
        rvalid_s  = 1'b0;
        case (r_state_r)
            R_IDLE: begin
                arready_s = ready_en_r;
                if (ready_en_r && s_arvalid) begin
                    r_next_s = R_DATA;
                end else begin
                    r_next_s = R_IDLE;
                end
            end
            R_DATA: begin
                rvalid_s = 1'b1;
                if (s_rready) begin
                    r_next_s = R_IDLE;
                end else begin
                    r_next_s = R_DATA;
                end
            end
            default: r_next_s = R_IDLE;
        endcase
    end

    // Read data mux; CTRL[0] is write-only and always reads back 0.
    always_comb begin
        rd_mux_s = 32'h0000_0000;
        case (rd_sel_s)
            REG_CTRL:   rd_mux_s = {30'd0, srst_r, 1'b0};
            REG_STATUS: rd_mux_s = {30'd0, done_r, role_busy};
            REG_SRC:    rd_mux_s = src_r;
            REG_DST:    rd_mux_s = dst_r;
            REG_LEN:    rd_mux_s = len_r;
            REG_CYCLES: rd_mux_s = cycles_r;
            REG_ID:     rd_mux_s = CORE_ID;
            REG_RSVD:   rd_mux_s = 32'h0000_0000;
            default:    rd_mux_s = 32'h0000_0000;
        endcase
    end

    // Read data capture at the AR handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= 32'h0000_0000;
        end else if (rd_fire_s) begin
            rdata_r <= rd_mux_s;
        end else begin
            rdata_r <= rdata_r;
        end
    end

    // Control/descriptor registers and the start pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            srst_r       <= 1'b0;
            src_r        <= 32'h0000_0000;
            dst_r        <= 32'h0000_0000;
            len_r        <= 32'h0000_0000;
            role_start_r <= 1'b0;
        end else begin
            role_start_r <= start_accept_s;
            if (ctrl_wr_s) begin
                srst_r <= s_wdata[1];
            end
            if (wr_fire_s) begin
                case (wr_sel_s)
                    REG_SRC: src_r <= apply_strb(src_r, s_wdata, s_wstrb);
                    REG_DST: dst_r <= apply_strb(dst_r, s_wdata, s_wstrb);
                    REG_LEN: len_r <= apply_strb(len_r, s_wdata, s_wstrb);
                    default: ;
                endcase
            end
        end
    end

    // Sticky done flag (set beats clear) and saturating busy-cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_r   <= 1'b0;
            cycles_r <= 32'h0000_0000;
        end else begin
            if (srst_r) begin
                done_r <= 1'b0;
            end else if (role_done) begin
                done_r <= 1'b1;
            end else if (start_accept_s || done_w1c_s) begin
                done_r <= 1'b0;
            end else begin
                done_r <= done_r;
            end
            if (srst_r || start_accept_s) begin
                cycles_r <= 32'h0000_0000;
            end else if (role_busy && (cycles_r != 32'hFFFF_FFFF)) begin
                cycles_r <= cycles_r + 32'd1;
            end else begin
                cycles_r <= cycles_r;
            end
        end
    end

    assign s_awready     = awready_s;
    assign s_wready      = wready_s;
    assign s_bvalid      = bvalid_s;
    assign s_bresp       = AXI_RESP_OKAY;
    assign s_arready     = arready_s;
    assign s_rvalid      = rvalid_s;
    assign s_rdata       = rdata_r;
    assign s_rresp       = AXI_RESP_OKAY;
    assign role_start    = role_start_r;
    assign role_srst     = srst_r;
    assign role_src_addr = src_r;
    assign role_dst_addr = dst_r;
    assign role_len      = len_r;

endmodule

// File: tb/tb_role_ctrl_regs.sv
// Self-checking bench for role_ctrl_regs: register-access vector table plus
// hand-written start/busy/done, reset and backpressure sequences.
module tb_role_ctrl_regs;

    localparam logic [31:0] CORE_ID = 32'h5A5A0001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  s_awaddr = 8'h00;
    logic        s_awvalid = 1'b0;
    logic        s_awready;
    logic [31:0] s_wdata = 32'h0;
    logic [3:0]  s_wstrb = 4'h0;
    logic        s_wvalid = 1'b0;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready = 1'b1;
    logic [7:0]  s_araddr = 8'h00;
    logic        s_arvalid = 1'b0;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready = 1'b1;
    logic        role_start, role_srst;
    logic [31:0] role_src_addr, role_dst_addr, role_len;
    logic        role_busy = 1'b0;
    logic        role_done = 1'b0;

    role_ctrl_regs #(.ADDR_W(8), .DATA_W(32), .CORE_ID(CORE_ID)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .role_start(role_start), .role_srst(role_srst),
        .role_src_addr(role_src_addr), .role_dst_addr(role_dst_addr), .role_len(role_len),
        .role_busy(role_busy), .role_done(role_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        string       name;
    } rexp_t;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    rexp_t       rq[$];
    logic [1:0]  bq[$];
    int          tests = 0;
    int          fails = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          start_cnt = 0;
    int          rmode = 0;
    int          bmode = 0;
    logic        r_hold = 1'b0;
    logic [31:0] r_hold_data = 32'h0;
    logic        b_hold = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Ready drivers: 0 = always ready, 1 = held low, 2 = random.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            s_rready = (rmode == 2) ? 1'($urandom_range(0, 1)) : (rmode == 0);
            s_bready = (bmode == 2) ? 1'($urandom_range(0, 1)) : (bmode == 0);
        end
    end

    // Response monitor and scoreboard; samples mid-cycle before the next posedge.
    initial begin
        rexp_t e;
        logic [1:0] eb;
        forever begin
            @(negedge clk);
            #3;
            if (!rst_n) begin
                r_hold = 1'b0;
                b_hold = 1'b0;
            end else begin
                if (r_hold) begin
                    check("rvalid_stable", 32'(s_rvalid), 32'd1);
                    check("rdata_stable", s_rdata, r_hold_data);
                end
                if (b_hold) check("bvalid_stable", 32'(s_bvalid), 32'd1);
                if (s_rvalid && s_rready) begin
                    if (rq.size() == 0) begin
                        timeout("r_unexpected_response");
                    end else begin
                        e = rq.pop_front();
                        check(e.name, s_rdata, e.data);
                        check("rresp", 32'(s_rresp), 32'd0);
                    end
                    rd_cnt++;
                end
                if (s_bvalid && s_bready) begin
                    if (bq.size() == 0) begin
                        timeout("b_unexpected_response");
                    end else begin
                        eb = bq.pop_front();
                        check("bresp", 32'(s_bresp), 32'(eb));
                    end
                    wr_cnt++;
                end
                if (role_start) begin
                    start_cnt++;
                    check("start_align", 32'(s_bvalid), 32'd1);
                end
                r_hold      = s_rvalid && !s_rready;
                r_hold_data = s_rdata;
                b_hold      = s_bvalid && !s_bready;
            end
        end
    end

    task automatic wait_rd(input int c0);
        int n = 0;
        while (rd_cnt == c0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (rd_cnt == c0) timeout("read_response");
    endtask

    task automatic wait_wr(input int c0);
        int n = 0;
        while (wr_cnt == c0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (wr_cnt == c0) timeout("write_response");
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        int c0 = wr_cnt;
        int n = 0;
        @(negedge clk);
        s_awaddr = a; s_wdata = d; s_wstrb = s;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        bq.push_back(2'b00);
        #1;
        while (!s_awready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!s_awready) timeout("aw_handshake");
        @(negedge clk);
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        wait_wr(c0);
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] e, input string nm);
        int c0 = rd_cnt;
        int n = 0;
        rexp_t x;
        x.data = e;
        x.name = nm;
        @(negedge clk);
        s_araddr = a; s_arvalid = 1'b1;
        rq.push_back(x);
        #1;
        while (!s_arready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!s_arready) timeout("ar_handshake");
        @(negedge clk);
        s_arvalid = 1'b0;
        wait_rd(c0);
    endtask

    initial begin
        vec_t vecs[10];
        int   c0, sc0;

        vecs[0] = '{8'h0C, 32'hDEADBEEF, 4'hF,    32'hDEADBEEF};
        vecs[1] = '{8'h0C, 32'h11223344, 4'b1000, 32'h11ADBEEF};
        vecs[2] = '{8'h10, 32'hAABBCCDD, 4'b0010, 32'h0000CC00};
        vecs[3] = '{8'h10, 32'h00000012, 4'b0001, 32'h0000CC12};
        vecs[4] = '{8'h18, 32'hFFFFFFFF, 4'hF,    CORE_ID};
        vecs[5] = '{8'h1C, 32'h12345678, 4'hF,    32'h00000000};
        vecs[6] = '{8'h14, 32'hFFFFFFFF, 4'hF,    32'h00000000};
        vecs[7] = '{8'h04, 32'h00000001, 4'hF,    32'h00000000};
        vecs[8] = '{8'h00, 32'h00000002, 4'b0010, 32'h00000000};
        vecs[9] = '{8'h08, 32'hCAFEF00D, 4'b0101, 32'h10FE000D};

        // Reset values while reset is held.
        repeat (3) @(negedge clk);
        check("rst_arready", 32'(s_arready), 32'd0);
        check("rst_awready", 32'(s_awready), 32'd0);
        check("rst_bvalid", 32'(s_bvalid), 32'd0);
        check("rst_rvalid", 32'(s_rvalid), 32'd0);
        check("rst_rdata", s_rdata, 32'd0);
        check("rst_role_start", 32'(role_start), 32'd0);
        check("rst_role_srst", 32'(role_srst), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("post_rst_arready", 32'(s_arready), 32'd1);

        // Reset in the middle of a read drops the response and clears registers.
        wr(8'h08, 32'h00001234, 4'hF);
        check("src_out_pre_reset", role_src_addr, 32'h00001234);
        rmode = 1;
        @(negedge clk);
        s_araddr = 8'h08; s_arvalid = 1'b1;
        @(negedge clk);
        s_arvalid = 1'b0;
        #1;
        check("midread_rvalid", 32'(s_rvalid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midread_rst_rvalid", 32'(s_rvalid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rmode = 0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("midread_arready", 32'(s_arready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            rd(8'(i * 4), (i == 6) ? CORE_ID : 32'h0, "reset_reg_read");
        end
        check("src_out_post_reset", role_src_addr, 32'h0);

        // AW presented three cycles ahead of W: no handshake until W arrives.
        c0 = wr_cnt;
        @(negedge clk);
        s_awaddr = 8'h08; s_awvalid = 1'b1; s_wvalid = 1'b0;
        bq.push_back(2'b00);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("aw_alone_awready", 32'(s_awready), 32'd0);
            check("aw_alone_wready", 32'(s_wready), 32'd0);
            @(negedge clk);
        end
        s_wdata = 32'h1000_0000; s_wstrb = 4'hF; s_wvalid = 1'b1;
        #1;
        check("aw_w_awready", 32'(s_awready), 32'd1);
        check("aw_w_wready", 32'(s_wready), 32'd1);
        @(negedge clk);
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        wait_wr(c0);
        rd(8'h08, 32'h1000_0000, "src_readback");

        // Register vector table: write then read back.
        for (int i = 0; i < 10; i++) begin
            wr(vecs[i].addr, vecs[i].data, vecs[i].strb);
            rd(vecs[i].addr, vecs[i].exp, "vec_readback");
        end
        check("role_src_addr", role_src_addr, 32'h10FE000D);
        check("role_dst_addr", role_dst_addr, 32'h11ADBEEF);
        check("role_len", role_len, 32'h0000CC12);
        check("no_start_from_table", 32'(start_cnt), 32'd0);

        // Start, ten busy cycles, done pulse.
        sc0 = start_cnt;
        wr(8'h00, 32'h00000001, 4'hF);
        repeat (2) @(negedge clk);
        check("start_pulse_count", 32'(start_cnt - sc0), 32'd1);
        rd(8'h00, 32'h0, "ctrl_reads_zero");
        role_busy = 1'b1;
        repeat (10) @(negedge clk);
        role_busy = 1'b0;
        role_done = 1'b1;
        @(negedge clk);
        role_done = 1'b0;
        repeat (3) @(negedge clk);
        rd(8'h04, 32'h2, "status_done");
        rd(8'h14, 32'd10, "cycles_count");
        wr(8'h04, 32'h00000002, 4'hF);
        rd(8'h04, 32'h0, "status_w1c");

        // Start while busy, and while srst is set, are discarded.
        sc0 = start_cnt;
        role_busy = 1'b1;
        wr(8'h00, 32'h00000001, 4'hF);
        rd(8'h04, 32'h1, "status_busy");
        role_busy = 1'b0;
        wr(8'h00, 32'h00000002, 4'hF);
        check("role_srst_set", 32'(role_srst), 32'd1);
        wr(8'h00, 32'h00000003, 4'hF);
        repeat (2) @(negedge clk);
        check("blocked_start_count", 32'(start_cnt - sc0), 32'd0);
        rd(8'h00, 32'h2, "ctrl_srst_readback");
        rd(8'h14, 32'h0, "cycles_srst_clear");
        rd(8'h08, 32'h10FE000D, "src_kept_in_srst");
        wr(8'h00, 32'h00000000, 4'hF);
        check("role_srst_clear", 32'(role_srst), 32'd0);

        // Read held off for five cycles.
        c0 = rd_cnt;
        rmode = 1;
        begin
            rexp_t x;
            x.data = 32'h11ADBEEF;
            x.name = "bp_read_data";
            @(negedge clk);
            s_araddr = 8'h0C; s_arvalid = 1'b1;
            rq.push_back(x);
            @(negedge clk);
            s_arvalid = 1'b0;
        end
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_rvalid_held", 32'(s_rvalid), 32'd1);
            check("bp_rdata_held", s_rdata, 32'h11ADBEEF);
            @(negedge clk);
        end
        rmode = 0;
        wait_rd(c0);
        repeat (3) @(negedge clk);
        check("bp_read_once", 32'(rd_cnt - c0), 32'd1);

        // Write response held off for five cycles.
        c0 = wr_cnt;
        bmode = 1;
        @(negedge clk);
        s_awaddr = 8'h10; s_wdata = 32'h00000400; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        bq.push_back(2'b00);
        @(negedge clk);
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_bvalid_held", 32'(s_bvalid), 32'd1);
            @(negedge clk);
        end
        bmode = 0;
        wait_wr(c0);
        repeat (3) @(negedge clk);
        check("bp_write_once", 32'(wr_cnt - c0), 32'd1);
        check("bp_len_written", role_len, 32'h00000400);

        // Random backpressure on both response channels.
        rmode = 2;
        bmode = 2;
        for (int i = 1; i <= 6; i++) begin
            wr(8'h08, 32'(i) * 32'h01010101, 4'hF);
            rd(8'h08, 32'(i) * 32'h01010101, "rand_bp_readback");
        end
        rmode = 0;
        bmode = 0;
        repeat (4) @(negedge clk);
        check("rq_drained", 32'(rq.size()), 32'd0);
        check("bq_drained", 32'(bq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
